// File: rtl/stoch2bin_uni.sv
// rtl/stoch2bin_uni.sv - unipolar stochastic-to-binary converter over a 2^BITWIDTH sample window
// Optional macro STOCH2BIN_SAT_EN: saturate an all-ones window to 2^BITWIDTH-1 instead of wrapping to 0.
module stoch2bin_uni #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iClr,
  input  logic                iBitEn,
  input  logic                iBit,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oVal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [BITWIDTH-1:0] WIN_ONE  = {{(BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [BITWIDTH-1:0] WIN_LAST = {BITWIDTH{1'b1}};

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] win_q, win_d;
  logic [BITWIDTH:0]   ones_q, ones_d;
  logic [BITWIDTH-1:0] val_q, val_d;
  logic                valid_q, valid_d;

  logic                sample;
  logic                last_sample;
  logic [BITWIDTH:0]   ones_inc;
  logic [BITWIDTH-1:0] result;

  assign sample      = (state_q == S_COUNT) && iBitEn;
  assign last_sample = sample && (win_q == WIN_LAST);
  assign ones_inc    = ones_q + {{BITWIDTH{1'b0}}, iBit};

  // Only the all-ones window sets the top bit of the count.
`ifdef STOCH2BIN_SAT_EN
  assign result = ones_inc[BITWIDTH] ? {BITWIDTH{1'b1}} : ones_inc[BITWIDTH-1:0];
`else
  assign result = ones_inc[BITWIDTH-1:0];
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (iClr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (iStart) state_d = S_COUNT;
        S_COUNT: if (last_sample) state_d = S_DONE;
        S_DONE:  state_d = iStart ? S_COUNT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    oBusy  = (state_q == S_COUNT);
    oValid = valid_q;
    oVal   = val_q;
  end

  always_comb begin
    win_d   = win_q;
    ones_d  = ones_q;
    val_d   = val_q;
    valid_d = 1'b0;
    if (iClr) begin
      win_d  = '0;
      ones_d = '0;
      val_d  = '0;
    end else if (state_q != S_COUNT) begin
      win_d  = '0;
      ones_d = '0;
    end else if (sample) begin
      win_d = win_q + WIN_ONE;
      if (last_sample) begin
        ones_d  = '0;
        val_d   = result;
        valid_d = 1'b1;
      end else begin
        ones_d = ones_inc;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      win_q   <= '0;
      ones_q  <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      ones_q  <= ones_d;
      val_q   <= val_d;
      valid_q <= valid_d;
    end
  end

endmodule
